// File: rtl/sha256_block_ctrl_if.sv
// ---------------------------------------------------------------------------
// sha256_block_ctrl_if : block/digest handshake and core strobe bundle
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface sha256_block_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             blk_valid;
  logic             blk_first;
  logic             blk_last;
  logic             blk_ready;
  logic             abort;
  logic             digest_ack;
  logic             sched_load;
  logic             core_init;
  logic             core_start;
  logic             round_en;
  logic [5:0]       round_idx;
  logic             hash_add;
  logic             digest_valid;
  logic             busy;
  logic             seq_err;
  logic [CNT_W-1:0] blk_count;

  modport master (
    output blk_valid, blk_first, blk_last, abort, digest_ack,
    input  blk_ready, sched_load, core_init, core_start, round_en, round_idx,
           hash_add, digest_valid, busy, seq_err, blk_count
  );

  modport slave (
    input  blk_valid, blk_first, blk_last, abort, digest_ack,
    output blk_ready, sched_load, core_init, core_start, round_en, round_idx,
           hash_add, digest_valid, busy, seq_err, blk_count
  );
endinterface

`default_nettype wire

// File: rtl/sha256_block_ctrl.sv
// ---------------------------------------------------------------------------
// sha256_block_ctrl : SHA-256 block sequencer (accept, 64 rounds, commit, digest)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sha256_block_ctrl #(
  parameter int ROUNDS = 64,
  parameter int CNT_W  = 16
) (
  input  wire logic         clk,
  input  wire logic         n_rst,
  sha256_block_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUND = 2'd1,
    S_FINAL = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [5:0] c_LAST_RND = 6'(ROUNDS - 1);

  state_t           r_state;
  logic [5:0]       r_round_idx;
  logic             r_last_q;
  logic             r_msg_open;
  logic [CNT_W-1:0] r_blk_count;
  logic             r_seq_err;
  logic             r_round_en;
  logic             r_hash_add;
  logic             r_digest_valid;
  logic             r_busy;

  logic             w_blk_ready;
  logic             w_accept;
  logic             w_core_init;
  logic             w_seq_err_set;
  logic [CNT_W-1:0] w_cnt_next;

  // Gated by n_rst so nothing is accepted or strobed while reset is held.
  assign w_blk_ready   = n_rst && (r_state == S_IDLE) && !bus.abort;
  assign w_accept      = bus.blk_valid && w_blk_ready;
  assign w_core_init   = w_accept && (bus.blk_first || !r_msg_open);
  assign w_seq_err_set = (w_accept && (bus.blk_first == r_msg_open)) ||
                         (bus.digest_ack && (r_state != S_DONE));
  assign w_cnt_next    = w_core_init   ? CNT_W'(1) :
                         (&r_blk_count) ? r_blk_count : r_blk_count + CNT_W'(1);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state        <= S_IDLE;
      r_round_idx    <= 6'd0;
      r_last_q       <= 1'b0;
      r_msg_open     <= 1'b0;
      r_blk_count    <= '0;
      r_seq_err      <= 1'b0;
      r_round_en     <= 1'b0;
      r_hash_add     <= 1'b0;
      r_digest_valid <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      if (w_seq_err_set) r_seq_err <= 1'b1;
      if (bus.abort) begin
        r_state        <= S_IDLE;
        r_msg_open     <= 1'b0;
        r_round_idx    <= 6'd0;
        r_round_en     <= 1'b0;
        r_hash_add     <= 1'b0;
        r_digest_valid <= 1'b0;
        r_busy         <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_accept) begin
              r_state     <= S_ROUND;
              r_last_q    <= bus.blk_last;
              r_msg_open  <= 1'b1;
              r_round_idx <= 6'd0;
              r_blk_count <= w_cnt_next;
              r_round_en  <= 1'b1;
              r_busy      <= 1'b1;
            end
          end
          S_ROUND: begin
            if (r_round_idx == c_LAST_RND) begin
              r_state     <= S_FINAL;
              r_round_idx <= 6'd0;
              r_round_en  <= 1'b0;
              r_hash_add  <= 1'b1;
            end else begin
              r_round_idx <= r_round_idx + 6'd1;
            end
          end
          S_FINAL: begin
            r_hash_add <= 1'b0;
            if (r_last_q) begin
              r_state        <= S_DONE;
              r_msg_open     <= 1'b0;
              r_digest_valid <= 1'b1;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end
          S_DONE: begin
            if (bus.digest_ack) begin
              r_state        <= S_IDLE;
              r_digest_valid <= 1'b0;
              r_busy         <= 1'b0;
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.blk_ready    = w_blk_ready;
  assign bus.sched_load   = w_accept;
  assign bus.core_start   = w_accept;
  assign bus.core_init    = w_core_init;
  assign bus.round_en     = r_round_en;
  assign bus.round_idx    = r_round_idx;
  assign bus.hash_add     = r_hash_add;
  assign bus.digest_valid = r_digest_valid;
  assign bus.busy         = r_busy;
  assign bus.seq_err      = r_seq_err;
  assign bus.blk_count    = r_blk_count;

endmodule

`default_nettype wire
